// File: rtl/lift_call_scheduler_pkg.sv
// lift_pkg: shared types and constants for the lift call scheduler.
// FSM states, direction codes and the dispatch timeout.
package lift_pkg;

  localparam int FLOORS_DEF = 8;
  localparam int FW_DEF     = 3;
  localparam int WAIT_TMO   = 4;

  localparam logic [1:0] DIR_IDLE = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_WAIT_BUSY,
    S_TRAVEL
  } state_t;

endpackage

// File: rtl/lift_call_scheduler_if.sv
// lift_call_scheduler_if: request inputs, Lift feedback and dispatch outputs.
// master drives requests and Lift status; slave is the scheduler.
interface lift_call_scheduler_if #(
  parameter int FLOORS = lift_pkg::FLOORS_DEF,
  parameter int FW     = lift_pkg::FW_DEF
);

  logic              hall_req;
  logic [FW-1:0]     hall_f;
  logic              cab_req;
  logic [FW-1:0]     cab_f;
  logic [FW-1:0]     elev_f;
  logic              busy;
  logic [FW-1:0]     tgt_f;
  logic              tgt_vld;
  logic [1:0]        dir;
  logic [FLOORS-1:0] pend;
  logic              drop;

  modport master (
    output hall_req, hall_f, cab_req, cab_f, elev_f, busy,
    input  tgt_f, tgt_vld, dir, pend, drop
  );

  modport slave (
    input  hall_req, hall_f, cab_req, cab_f, elev_f, busy,
    output tgt_f, tgt_vld, dir, pend, drop
  );

endinterface

// File: rtl/lift_call_scheduler_floor_pick.sv
// lift_floor_pick: SCAN next-floor choice from a pending bitmap.
// Floor under the cabin wins; otherwise keep direction, flip when empty.
module lift_floor_pick
  import lift_pkg::*;
#(
  parameter int FLOORS = FLOORS_DEF,
  parameter int FW     = FW_DEF
) (
  input  logic [FLOORS-1:0] bm_i,
  input  logic [FW-1:0]     elev_f_i,
  input  logic [1:0]        dir_i,
  output logic [FW-1:0]     nxt_f_o,
  output logic [1:0]        nxt_dir_o,
  output logic              found_o
);

  logic          hit;
  logic          has_up;
  logic          has_dn;
  logic [FW-1:0] up_f;
  logic [FW-1:0] dn_f;
  logic [FW-1:0] du;
  logic [FW-1:0] dd;
  logic          go_up;
  logic          go_dn;

  // nearest pending floor above and below the cabin
  always_comb begin
    hit    = 1'b0;
    has_up = 1'b0;
    has_dn = 1'b0;
    up_f   = '0;
    dn_f   = '0;
    for (int i = FLOORS - 1; i >= 0; i--) begin
      if (bm_i[i] && FW'(i) > elev_f_i) begin
        has_up = 1'b1;
        up_f   = FW'(i);
      end
    end
    for (int i = 0; i < FLOORS; i++) begin
      if (bm_i[i] && FW'(i) < elev_f_i) begin
        has_dn = 1'b1;
        dn_f   = FW'(i);
      end
      if (bm_i[i] && FW'(i) == elev_f_i) hit = 1'b1;
    end
  end

  assign du = up_f - elev_f_i;
  assign dd = elev_f_i - dn_f;

  assign go_up = !hit && has_up &&
                 ((dir_i == DIR_UP) ||
                  (dir_i == DIR_DOWN && !has_dn) ||
                  (dir_i != DIR_UP && dir_i != DIR_DOWN &&
                   (!has_dn || du <= dd)));
  assign go_dn = !hit && has_dn && !go_up;

  // resolve the chosen floor and the direction it implies
  always_comb begin
    nxt_f_o   = elev_f_i;
    nxt_dir_o = dir_i;
    found_o   = hit | go_up | go_dn;
    unique case (1'b1)
      go_up: begin
        nxt_f_o   = up_f;
        nxt_dir_o = DIR_UP;
      end
      go_dn: begin
        nxt_f_o   = dn_f;
        nxt_dir_o = DIR_DOWN;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler: hall/cabin call bitmaps and one-at-a-time dispatch.
// LIFT_SCHED_CAB_PRIO_EN: serve cabin calls before hall calls.
module lift_call_scheduler
  import lift_pkg::*;
#(
  parameter int FLOORS = FLOORS_DEF,
  parameter int FW     = FW_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  lift_call_scheduler_if.slave bus_io
);

  state_t            state_q;
  logic [FW-1:0]     tgt_q;
  logic [1:0]        dir_q;
  logic              tgt_vld_q;
  logic              drop_q;
  logic [2:0]        cnt_q;
  logic [FLOORS-1:0] hall_q;
  logic [FLOORS-1:0] cab_q;
  logic [FLOORS-1:0] pend_q;
  logic [FLOORS-1:0] hall_d;
  logic [FLOORS-1:0] cab_d;
  logic [FLOORS-1:0] pend_d;
  logic [FLOORS-1:0] set_h;
  logic [FLOORS-1:0] set_c;
  logic [FLOORS-1:0] clr;
  logic [FLOORS-1:0] pick_bm;
  logic              hall_ok;
  logic              cab_ok;
  logic              tmo;
  logic              trip_end;
  logic              clr_en;
  logic [FW-1:0]     pk_f;
  logic [1:0]        pk_dir;
  logic              pk_found;

  assign hall_ok  = int'(bus_io.hall_f) < FLOORS;
  assign cab_ok   = int'(bus_io.cab_f) < FLOORS;
  assign tmo      = (state_q == S_WAIT_BUSY) && !bus_io.busy &&
                    (cnt_q == 3'(WAIT_TMO - 1));
  assign trip_end = (state_q == S_TRAVEL) && !bus_io.busy;
  assign clr_en   = (tmo || trip_end) && (bus_io.elev_f == tgt_q);

  // next bitmaps: retire the served floor, new requests override the clear
  always_comb begin
    set_h = '0;
    set_c = '0;
    clr   = '0;
    for (int i = 0; i < FLOORS; i++) begin
      set_h[i] = bus_io.hall_req && (int'(bus_io.hall_f) == i);
      set_c[i] = bus_io.cab_req && (int'(bus_io.cab_f) == i);
      clr[i]   = clr_en && (int'(tgt_q) == i);
    end
    hall_d = (hall_q & ~clr) | set_h;
    cab_d  = (cab_q & ~clr) | set_c;
    pend_d = hall_d | cab_d;
  end

`ifdef LIFT_SCHED_CAB_PRIO_EN
  assign pick_bm = (cab_q != '0) ? cab_q : (hall_q | cab_q);
`else
  assign pick_bm = hall_q | cab_q;
`endif

  lift_floor_pick #(
    .FLOORS (FLOORS),
    .FW     (FW)
  ) u_pick (
    .bm_i      (pick_bm),
    .elev_f_i  (bus_io.elev_f),
    .dir_i     (dir_q),
    .nxt_f_o   (pk_f),
    .nxt_dir_o (pk_dir),
    .found_o   (pk_found)
  );

  // request capture plus the dispatch FSM with registered outputs
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= S_IDLE;
      tgt_q     <= '0;
      dir_q     <= DIR_IDLE;
      tgt_vld_q <= 1'b0;
      drop_q    <= 1'b0;
      cnt_q     <= '0;
      hall_q    <= '0;
      cab_q     <= '0;
      pend_q    <= '0;
    end else begin
      hall_q    <= hall_d;
      cab_q     <= cab_d;
      pend_q    <= pend_d;
      drop_q    <= (bus_io.hall_req && !hall_ok) ||
                   (bus_io.cab_req && !cab_ok);
      tgt_vld_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pend_q != '0 && !bus_io.busy) state_q <= S_SELECT;
        end
        S_SELECT: begin
          if (pk_found) begin
            tgt_q     <= pk_f;
            dir_q     <= pk_dir;
            tgt_vld_q <= 1'b1;
            state_q   <= S_ISSUE;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_ISSUE: begin
          cnt_q   <= '0;
          state_q <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus_io.busy) state_q <= S_TRAVEL;
          else if (tmo) state_q <= S_IDLE;
          else cnt_q <= cnt_q + 3'd1;
        end
        S_TRAVEL: begin
          if (!bus_io.busy) begin
            state_q <= S_IDLE;
            if (pend_d == '0) dir_q <= DIR_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_io.tgt_f   = tgt_q;
  assign bus_io.tgt_vld = tgt_vld_q;
  assign bus_io.dir     = dir_q;
  assign bus_io.pend    = pend_q;
  assign bus_io.drop    = drop_q;

endmodule

// File: tb/tb_lift_call_scheduler.sv
// tb_lift_call_scheduler: directed scenarios plus random call traffic,
// checked against a floor-set model of the SCAN dispatch rules.
module tb_lift_call_scheduler;

  localparam int D_IDLE = 0;
  localparam int D_UP   = 1;
  localparam int D_DN   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   vec_n = 0;
  int   err_n = 0;
  bit   hm[8];
  bit   cm[8];
  int   mdir  = D_IDLE;
  int   elev_m = 0;
  int   tgt_m  = 0;

  lift_call_scheduler_if #(.FLOORS(8), .FW(3)) u_if ();
  lift_call_scheduler_if #(.FLOORS(6), .FW(3)) u_if6 ();

  lift_call_scheduler #(.FLOORS(8), .FW(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (u_if)
  );

  lift_call_scheduler #(.FLOORS(6), .FW(3)) dut6 (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (u_if6)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vec_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pm_bits();
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) b[k] = hm[k] | cm[k];
    return b;
  endfunction

  function automatic void clr_model();
    for (int k = 0; k < 8; k++) begin
      hm[k] = 1'b0;
      cm[k] = 1'b0;
    end
    mdir = D_IDLE;
  endfunction

  // SCAN rules on a plain floor set
  function automatic void ref_pick(output int f, output int nd);
    bit s[8];
    int up;
    int dn;
    up = -1;
    dn = -1;
    for (int k = 0; k < 8; k++) s[k] = hm[k] | cm[k];
`ifdef LIFT_SCHED_CAB_PRIO_EN
    begin : cabp
      bit anyc;
      anyc = 1'b0;
      for (int k = 0; k < 8; k++) anyc |= cm[k];
      if (anyc) for (int k = 0; k < 8; k++) s[k] = cm[k];
    end
`endif
    f  = -1;
    nd = mdir;
    if (s[elev_m]) begin
      f = elev_m;
      return;
    end
    for (int d = 1; d < 8; d++) begin
      if (up < 0 && elev_m + d < 8 && s[elev_m + d]) up = elev_m + d;
      if (dn < 0 && elev_m - d >= 0 && s[elev_m - d]) dn = elev_m - d;
    end
    if (mdir == D_UP) begin
      if (up >= 0) begin f = up; nd = D_UP; end
      else begin f = dn; nd = D_DN; end
    end else if (mdir == D_DN) begin
      if (dn >= 0) begin f = dn; nd = D_DN; end
      else begin f = up; nd = D_UP; end
    end else if (up >= 0 && (dn < 0 || up - elev_m <= elev_m - dn)) begin
      f = up; nd = D_UP;
    end else begin
      f = dn; nd = D_DN;
    end
  endfunction

  task automatic req(input bit h, input int hf, input bit c, input int cf);
    u_if.hall_req = h;
    u_if.hall_f   = 3'(hf);
    u_if.cab_req  = c;
    u_if.cab_f    = 3'(cf);
    if (h) hm[hf] = 1'b1;
    if (c) cm[cf] = 1'b1;
    @(negedge clk);
    u_if.hall_req = 1'b0;
    u_if.cab_req  = 1'b0;
  endtask

  task automatic req_rnd();
    req(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
        1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
  endtask

  task automatic dispatch(input string tag);
    int ef;
    int ed;
    int n;
    ref_pick(ef, ed);
    n = 0;
    while (u_if.tgt_vld !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_vld"}, 32'(u_if.tgt_vld), 1);
    chk({tag, "_tgt"}, 32'(u_if.tgt_f), ef);
    chk({tag, "_dir"}, 32'(u_if.dir), ed);
    mdir  = ed;
    tgt_m = ef;
  endtask

  task automatic trip_start();
    u_if.busy = 1'b1;
    @(negedge clk);
    chk("vld_one_cycle", 32'(u_if.tgt_vld), 0);
  endtask

  task automatic trip_end(input int stop_f, input int hold, input bit rnd);
    for (int k = 0; k < hold; k++) begin
      if (rnd && $urandom_range(0, 2) == 0) req_rnd();
      else @(negedge clk);
    end
    chk("tgt_stable", 32'(u_if.tgt_f), tgt_m);
    u_if.elev_f = 3'(stop_f);
    u_if.busy   = 1'b0;
    elev_m      = stop_f;
    @(negedge clk);
    if (stop_f == tgt_m) begin
      hm[tgt_m] = 1'b0;
      cm[tgt_m] = 1'b0;
    end
    if (pm_bits() == 8'h00) mdir = D_IDLE;
    chk("trip_pend", 32'(u_if.pend), 32'(pm_bits()));
    chk("trip_dir", 32'(u_if.dir), mdir);
  endtask

  task automatic quiet(input string tag, input int n);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (u_if.tgt_vld === 1'b1) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic preload(input int h, input int hf, input int c, input int cf);
    u_if.busy = 1'b1;
    req(1'(h), hf, 1'(c), cf);
    u_if.busy = 1'b0;
  endtask

  initial begin
    int hold;
    int stop;
    int guard;
    u_if.hall_req  = 1'b0;
    u_if.hall_f    = '0;
    u_if.cab_req   = 1'b0;
    u_if.cab_f     = '0;
    u_if.elev_f    = '0;
    u_if.busy      = 1'b0;
    u_if6.hall_req = 1'b0;
    u_if6.hall_f   = '0;
    u_if6.cab_req  = 1'b0;
    u_if6.cab_f    = '0;
    u_if6.elev_f   = '0;
    u_if6.busy     = 1'b1;
    clr_model();
    repeat (2) @(negedge clk);
    chk("rst_tgt_f", 32'(u_if.tgt_f), 0);
    chk("rst_tgt_vld", 32'(u_if.tgt_vld), 0);
    chk("rst_dir", 32'(u_if.dir), 0);
    chk("rst_pend", 32'(u_if.pend), 0);
    chk("rst_drop", 32'(u_if.drop), 0);
    rst_n = 1'b0;
    @(negedge clk);

    u_if6.hall_req = 1'b1;
    u_if6.hall_f   = 3'd7;
    @(negedge clk);
    u_if6.hall_req = 1'b0;
    chk("drop_oor", 32'(u_if6.drop), 1);
    chk("drop_nostate", 32'(u_if6.pend), 0);
    @(negedge clk);
    chk("drop_pulse", 32'(u_if6.drop), 0);
    u_if6.hall_req = 1'b1;
    u_if6.hall_f   = 3'd5;
    u_if6.cab_req  = 1'b1;
    u_if6.cab_f    = 3'd6;
    @(negedge clk);
    u_if6.hall_req = 1'b0;
    u_if6.cab_req  = 1'b0;
    chk("drop_mixed", 32'(u_if6.drop), 1);
    chk("drop_keep_ok", 32'(u_if6.pend), 32'h20);

    req(1'b1, 3, 1'b0, 0);
    chk("sc_pend", 32'(u_if.pend), 32'h08);
    chk("sc_vld_e0", 32'(u_if.tgt_vld), 0);
    @(negedge clk);
    chk("sc_vld_e1", 32'(u_if.tgt_vld), 0);
    @(negedge clk);
    chk("sc_vld_e2", 32'(u_if.tgt_vld), 1);
    dispatch("sc");
    trip_start();
    trip_end(3, 9, 1'b0);

    u_if.busy = 1'b1;
    req(1'b1, 4, 1'b1, 1);
    req(1'b0, 0, 1'b1, 4);
    @(negedge clk);
    chk("dd_pend", 32'(u_if.pend), 32'h12);
    u_if.busy = 1'b0;
    dispatch("dd1");
    trip_start();
    trip_end(4, 3, 1'b0);
    dispatch("dd2");
    trip_start();
    trip_end(1, 3, 1'b0);
    quiet("dd_nodup", 10);

    preload(1, 2, 0, 0);
    dispatch("scan0");
    trip_start();
    req(1'b1, 0, 1'b0, 0);
    req(1'b1, 5, 1'b1, 7);
    trip_end(2, 2, 1'b0);
    chk("scan_pend", 32'(u_if.pend), 32'hA1);
    dispatch("scan1");
    chk("scan_first", 32'(u_if.tgt_f), 5);
    trip_start();
    trip_end(5, 3, 1'b0);
    dispatch("scan2");
    chk("scan_second", 32'(u_if.tgt_f), 7);
    trip_start();
    trip_end(7, 3, 1'b0);
    dispatch("scan3");
    chk("scan_third", 32'(u_if.tgt_f), 0);
    chk("scan_turn", 32'(u_if.dir), 2);
    trip_start();
    trip_end(0, 3, 1'b0);

    u_if.elev_f = 3'd6;
    elev_m      = 6;
    preload(1, 6, 0, 0);
    dispatch("to6");
    repeat (4) @(negedge clk);
    chk("to6_hold", 32'(u_if.pend), 32'h40);
    @(negedge clk);
    hm[6] = 1'b0;
    cm[6] = 1'b0;
    chk("to6_clr", 32'(u_if.pend), 32'(pm_bits()));

    u_if.elev_f = 3'd2;
    elev_m      = 2;
    preload(1, 6, 0, 0);
    dispatch("to2");
    repeat (5) @(negedge clk);
    chk("to2_keep", 32'(u_if.pend), 32'h40);
    dispatch("to2_re");
    trip_start();
    trip_end(6, 3, 1'b0);

    preload(1, 5, 0, 0);
    dispatch("rt");
    trip_start();
    req(1'b1, 0, 1'b1, 2);
    req(1'b1, 7, 1'b0, 0);
    chk("rt_pend", 32'(u_if.pend), 32'hA5);
    #2 rst_n = 1'b1;
    #1;
    chk("rt_tgt_f", 32'(u_if.tgt_f), 0);
    chk("rt_vld", 32'(u_if.tgt_vld), 0);
    chk("rt_dir", 32'(u_if.dir), 0);
    chk("rt_pend0", 32'(u_if.pend), 0);
    chk("rt_drop", 32'(u_if.drop), 0);
    @(negedge clk);
    rst_n     = 1'b0;
    u_if.busy = 1'b0;
    clr_model();
    quiet("rt_quiet", 12);
    chk("rt_pend_after", 32'(u_if.pend), 0);

    preload(0, 0, 1, 3);
    dispatch("rs");
    #2 rst_n = 1'b1;
    #1;
    chk("rs_vld_async", 32'(u_if.tgt_vld), 0);
    @(negedge clk);
    rst_n = 1'b0;
    clr_model();

    u_if.elev_f = 3'd0;
    elev_m      = 0;
    preload(1, 1, 1, 6);
    dispatch("prio");
`ifdef LIFT_SCHED_CAB_PRIO_EN
    chk("prio_first", 32'(u_if.tgt_f), 6);
`else
    chk("prio_first", 32'(u_if.tgt_f), 1);
`endif
    trip_start();
    trip_end(tgt_m, 3, 1'b0);
    guard = 0;
    while (pm_bits() != 8'h00 && guard < 8) begin
      dispatch("prio_rest");
      trip_start();
      trip_end(tgt_m, 3, 1'b0);
      guard++;
    end

    for (int r = 0; r < 25; r++) begin
      if (pm_bits() == 8'h00) begin
        u_if.busy = 1'b1;
        repeat ($urandom_range(1, 3)) req_rnd();
        if (pm_bits() == 8'h00) req(1'b1, int'($urandom_range(0, 7)), 1'b0, 0);
        u_if.busy = 1'b0;
      end
      dispatch("rnd");
      trip_start();
      hold = int'($urandom_range(2, 8));
      stop = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : tgt_m;
      trip_end(stop, hold, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
